// File: rtl/wmem_pkg.sv
// Shared widths, descriptor layout, FSM states and config-select codes
// for the sparse-weight streaming memory.
package wmem_pkg;

  localparam int DATA_W   = 16;
  localparam int C_W      = 5;
  localparam int R_W      = 2;
  localparam int K_W      = 5;
  localparam int PTR_W    = 11;
  localparam int ROW_AW   = 9;
  localparam int N_LAYER  = 3;
  localparam int N_STRIPE = 3;
  localparam int NS       = N_LAYER * N_STRIPE;
  localparam int LAYER_W  = $clog2(N_LAYER);
  localparam int STRIPE_W = $clog2(N_STRIPE);
  localparam int SLICE_W  = $clog2(NS);
  localparam int NZ_W     = DATA_W + C_W;
  localparam int ROW_W    = R_W + K_W + PTR_W;

  localparam logic [1:0] CFG_NZ   = 2'd0;
  localparam logic [1:0] CFG_ROW  = 2'd1;
  localparam logic [1:0] CFG_DESC = 2'd2;

  // Packed MSB-first, so row_base lands in the low bits of the config word.
  typedef struct packed {
    logic [ROW_AW:0]   row_cnt;
    logic [PTR_W-1:0]  nz_base;
    logic [ROW_AW-1:0] row_base;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW_RD,
    ST_ROW_WAIT,
    ST_NZ_STREAM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/wmem_sram.sv
// Simple dual-port SRAM model: one write port, one registered read port.
module wmem_sram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wmem_stream.sv
// CSR sparse-weight store for N_LAYER x N_STRIPE slices, loaded over a config
// port and streamed one slice at a time to the PE array as valid/ready beats.
module wmem_stream
  import wmem_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cfg_we,
  input  logic [1:0]               i_cfg_sel,
  input  logic [PTR_W-1:0]         i_cfg_addr,
  input  logic [31:0]              i_cfg_wdata,
  input  logic                     i_req_valid,
  input  logic [LAYER_W-1:0]       i_req_layer,
  input  logic [STRIPE_W-1:0]      i_req_stripe,
  output logic                     o_req_ready,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_data,
  output logic [C_W-1:0]           o_c_idx,
  output logic [R_W-1:0]           o_r_idx,
  output logic [K_W-1:0]           o_k_idx,
  output logic                     o_last_row,
  output logic                     o_last,
  output logic                     o_done,
  output logic                     o_err,
  output logic                     o_busy
);

  state_t             state, state_nxt;
  desc_t              desc_tbl [NS];
  desc_t              cur_desc;
  logic [SLICE_W-1:0] req_slice;
  logic [ROW_AW:0]    row_j;
  logic [PTR_W-1:0]   prev_end, beat_ptr, row_end, row_pos, nz_off, nz_raddr;
  logic [ROW_AW-1:0]  row_raddr;
  logic [NZ_W-1:0]    nz_rdata;
  logic [ROW_W-1:0]   row_rdata;
  logic               valid_q, err_q, idle, req_ok, accept, bad_req, handshake;
  logic               beat_last_row, rows_left, row_nonempty, row_re, nz_re;
  logic               nz_we, row_we, desc_we;
  logic [1:0]         unused_cfg;

  assign idle      = (state == ST_IDLE);
  assign req_slice = SLICE_W'(i_req_layer) * SLICE_W'(N_STRIPE) + SLICE_W'(i_req_stripe);
  assign req_ok    = (i_req_layer < LAYER_W'(N_LAYER)) && (i_req_stripe < STRIPE_W'(N_STRIPE));
  assign accept    = idle && i_req_valid && req_ok;
  assign bad_req   = idle && i_req_valid && !req_ok;
  assign handshake = valid_q && i_ready;

  assign row_pos       = row_rdata[ROW_W-1 -: PTR_W];
  assign row_nonempty  = (row_pos > prev_end);
  assign rows_left     = ({1'b0, row_j} + (ROW_AW+2)'(1)) < {1'b0, cur_desc.row_cnt};
  assign beat_last_row = valid_q && ((beat_ptr + PTR_W'(1)) == row_end);

  assign row_raddr = cur_desc.row_base + row_j[ROW_AW-1:0];
  assign nz_off    = (state == ST_ROW_WAIT) ? prev_end : beat_ptr + PTR_W'(1);
  assign nz_raddr  = cur_desc.nz_base + nz_off;

  // Config writes only land while idle; out-of-range row/descriptor addresses are dropped.
  assign nz_we      = i_cfg_we && idle && (i_cfg_sel == CFG_NZ);
  assign row_we     = i_cfg_we && idle && (i_cfg_sel == CFG_ROW) && (i_cfg_addr[PTR_W-1:ROW_AW] == '0);
  assign desc_we    = i_cfg_we && idle && (i_cfg_sel == CFG_DESC) && (i_cfg_addr < PTR_W'(NS));
  assign unused_cfg = i_cfg_wdata[31:30];

  wmem_sram #(.WIDTH(NZ_W), .DEPTH(2**PTR_W)) u_nz_mem (
    .clk   (i_clk),
    .we    (nz_we),
    .waddr (i_cfg_addr),
    .wdata (i_cfg_wdata[NZ_W-1:0]),
    .re    (nz_re),
    .raddr (nz_raddr),
    .rdata (nz_rdata)
  );

  wmem_sram #(.WIDTH(ROW_W), .DEPTH(2**ROW_AW)) u_row_mem (
    .clk   (i_clk),
    .we    (row_we),
    .waddr (i_cfg_addr[ROW_AW-1:0]),
    .wdata (i_cfg_wdata[ROW_W-1:0]),
    .re    (row_re),
    .raddr (row_raddr),
    .rdata (row_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NS; i++) desc_tbl[i] <= '0;
    end else if (desc_we) begin
      desc_tbl[i_cfg_addr[SLICE_W-1:0]] <= desc_t'(i_cfg_wdata[DESC_W-1:0]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    row_re    = 1'b0;
    nz_re     = 1'b0;
    case (state)
      ST_IDLE:      if (accept) state_nxt = ST_ROW_RD;
      ST_ROW_RD: begin
        row_re    = 1'b1;
        state_nxt = (cur_desc.row_cnt == '0) ? ST_DONE : ST_ROW_WAIT;
      end
      ST_ROW_WAIT: begin
        if (row_nonempty) begin
          nz_re     = 1'b1;
          state_nxt = ST_NZ_STREAM;
        end else begin
          state_nxt = rows_left ? ST_ROW_RD : ST_DONE;
        end
      end
      ST_NZ_STREAM: begin
        if (handshake) begin
          if (!beat_last_row) nz_re = 1'b1;
          else                state_nxt = rows_left ? ST_ROW_RD : ST_DONE;
        end
      end
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Walk rows and nonzero offsets; prev_end only advances past a strictly larger pos_ptr.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_desc <= '0;
      row_j    <= '0;
      prev_end <= '0;
      beat_ptr <= '0;
      row_end  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= bad_req;
      if (accept) begin
        cur_desc <= desc_tbl[req_slice];
        row_j    <= '0;
        prev_end <= '0;
      end
      case (state)
        ST_ROW_WAIT: begin
          if (row_nonempty) begin
            beat_ptr <= prev_end;
            row_end  <= row_pos;
            prev_end <= row_pos;
            valid_q  <= 1'b1;
          end else if (rows_left) begin
            row_j <= row_j + 1'b1;
          end
        end
        ST_NZ_STREAM: begin
          if (handshake) begin
            if (!beat_last_row) begin
              beat_ptr <= beat_ptr + PTR_W'(1);
            end else begin
              valid_q <= 1'b0;
              if (rows_left) row_j <= row_j + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = valid_q ? nz_rdata[DATA_W-1:0] : '0;
  assign o_c_idx     = valid_q ? nz_rdata[DATA_W +: C_W] : '0;
  assign o_r_idx     = valid_q ? row_rdata[R_W-1:0] : '0;
  assign o_k_idx     = valid_q ? row_rdata[R_W +: K_W] : '0;
  assign o_last_row  = beat_last_row;
  assign o_last      = beat_last_row && !rows_left;
  assign o_done      = (state == ST_DONE);
  assign o_err       = err_q;
  assign o_req_ready = idle;
  assign o_busy      = !idle;

endmodule
